// File: rtl/countdown_timer_if.sv
// Control and status bundle for the BCD countdown timer.
// The master drives the controls; the slave (the timer) returns count and status.
interface countdown_timer_if;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic [1:0]  state;

  modport master (
    output tick, load, load_value, start, pause,
    input  count, running, expired, state
  );

  modport slave (
    input  tick, load, load_value, start, pause,
    output count, running, expired, state
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause control and a one-cycle expiry pulse.
// All outputs registered; inputs take effect on the next rising edge, priority load > start > pause > tick.
module countdown_timer #(
  parameter int MAX_MIN_TENS = 9
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN_TENS);

  state_e      state_d, state_q;
  logic [15:0] count_d, count_q;
  logic        expired_d, expired_q;
  logic        running_d, running_q;

  function automatic logic [15:0] sanitize(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    mt = (v[15:12] > MAX_T) ? MAX_T : v[15:12];
    mo = (v[11:8]  > 4'd9)  ? 4'd9  : v[11:8];
    st = (v[7:4]   > 4'd5)  ? 4'd5  : v[7:4];
    so = (v[3:0]   > 4'd9)  ? 4'd9  : v[3:0];
    return {mt, mo, st, so};
  endfunction

  // Only called with a non-zero count, so min_tens never underflows.
  function automatic logic [15:0] dec_bcd(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (bus.load) begin
      count_d = sanitize(bus.load_value);
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && (count_q != 16'h0000)) state_d = RUN;
        end
        RUN: begin
          if (bus.start) begin
            state_d = RUN;
          end else if (bus.pause) begin
            state_d = PAUSED;
          end else if (bus.tick && (count_q != 16'h0000)) begin
            count_d = dec_bcd(count_q);
            if (count_d == 16'h0000) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (bus.start) state_d = RUN;
        end
        DONE: begin
          count_d = 16'h0000;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.state   = state_q;
  assign bus.expired = expired_q;
  assign bus.running = running_q;

endmodule
